muldiv_seq: RTL
===============

Name: muldiv_seq

Overview:
- Iterative sequencer for the RV32M multiply/divide operations. It sits in the execute stage beside the single-cycle ALU.
- It accepts one M-extension op from EX and stalls the pipeline while it iterates. It returns a 32-bit result with a one-cycle done pulse, which writeback muxes in place of the ALU result.
- It is built from a shift-add multiplier and a restoring divider that share one FSM and one iteration counter.

Parameters:
- XLEN, 32, operand/result width.
- CNT_W, $clog2(XLEN), iteration counter width.

Ports:
- i_clk  in  1  clock; all state updates on rising edge.
- i_rst_n  in  1  reset; asynchronous, active-low.
- i_start  in  1  EX holds a valid M op (OP=0110011, funct7=0000001); held high while stalled.
- i_funct3  in  3  000 mul, 001 mulh, 010 mulhsu, 011 mulhu, 100 div, 101 divu, 110 rem, 111 remu.
- i_operand_a  in  XLEN  rs1 data (forwarded).
- i_operand_b  in  XLEN  rs2 data (forwarded).
- i_flush  in  1  kill the in-flight op (branch/jump redirect).
- o_stall  out  1  freeze IF/ID/EX pipeline registers.
- o_done  out  1  one-cycle pulse; o_result valid this cycle.
- o_result  out  XLEN  registered result.

Behaviour:
- Reset (i_rst_n low, async):
  - state=IDLE; counter, operand/accumulator regs, o_result and o_done cleared to 0.
  - o_stall forced 0 while i_rst_n is low.
  - Reset mid-operation discards the op with no done pulse.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - Accept when i_start=1 and i_flush=0.
  - Latch op, operand signs and magnitudes. Sign rules:
    - mul/mulh/div/rem: both operands signed.
    - mulhsu: a signed, b unsigned.
    - mulhu/divu/remu/mul low word: unsigned magnitudes are acceptable for mul since the low word is sign-agnostic, but the implementation treats mul as signed×signed for uniformity.
  - Special cases go directly to DONE with o_result loaded:
    - div/divu by zero: quotient 0xFFFFFFFF.
    - rem/remu by zero: rem = dividend a.
    - div overflow (a=0x80000000, b=0xFFFFFFFF, signed): quotient 0x80000000; rem gives 0.
  - Otherwise: counter<=0, state<=CALC.
- CALC, one iteration per cycle:
  - mul: if multiplier LSB=1, add multiplicand into the 2·XLEN accumulator high half; shift right 1.
  - div: shift {rem,quot} left 1; trial-subtract divisor; if no borrow, keep the difference and set quot LSB.
  - counter++; when counter==XLEN-1, state<=FIX.
- FIX:
  - Negate the 64-bit product if signs differ (signed ops).
  - Quotient sign = sa^sb; remainder sign = sa.
  - Select low word (mul), high word (mulh/mulhsu/mulhu), quotient, or remainder into o_result.
  - state<=DONE.
- DONE:
  - o_done=1, o_stall=0; the pipeline advances and captures o_result.
  - i_start ignored (same instruction leaving EX); state<=IDLE.
- Stall: o_stall = (state==IDLE & i_start & ~i_flush) | state==CALC | state==FIX. Combinational from state and inputs.
- Latency:
  - Start sampled at edge k gives o_done high in the cycle after edge k+XLEN+1, i.e. 34 cycles of stall for XLEN=32.
  - Special cases: o_done in the cycle after edge k (1 stall cycle).
- Back-to-back M ops: next op is seen in IDLE the cycle after DONE and accepted normally. No idle bubble beyond DONE.
- Flush:
  - i_flush=1 in any state forces state<=IDLE on the next edge, with no o_done pulse; o_result holds its old value.
  - Flush wins over start in the same cycle.
  - Flush during DONE: the pulse for that cycle is still asserted; writeback qualifies it with its own valid.
- Operands are sampled only at accept; changes on i_operand_a/b during CALC have no effect.
- All arithmetic is modulo 2^(2·XLEN) inside the accumulator; no flags are produced.

Decomposition:
- Package muldiv_pkg:
  - md_op_e enum over funct3 (MUL..REMU).
  - md_state_e enum (IDLE, CALC, FIX, DONE).
  - Constants OP_MULDIV=7'b0110011 and F7_MULDIV=7'b0000001 for the decoder.
- Sub-module muldiv_iter: holds the accumulator/remainder/quotient registers and the per-cycle shift-add / trial-subtract step under load/step/fix controls.
- muldiv_seq keeps the FSM, counter, special-case detection, stall/done logic and result select.

Test Plan:
- mul a=7, b=0xFFFFFFFD (-3), start held → o_stall high 34 cycles; o_done pulse with o_result=0xFFFFFFEB; state IDLE next.
- mulhu a=b=0xFFFFFFFF → o_result=0xFFFFFFFE. mulh same operands → 0x00000000. mulhsu a=0xFFFFFFFF, b=2 → 0xFFFFFFFF.
- div a=0xFFFFFFF9 (-7), b=2 → quotient 0xFFFFFFFD. rem same operands → 0xFFFFFFFF. divu a=100, b=7 → 14. remu → 2.
- Special cases, each with o_done in the cycle after accept and 1 stall cycle:
  - div b=0, a=5 → 0xFFFFFFFF.
  - rem b=0, a=5 → 5.
  - div a=0x80000000, b=0xFFFFFFFF → 0x80000000; rem of same → 0.
- i_flush pulsed at CALC iteration 10 → IDLE next edge, o_stall low, no o_done. A following mul 3×4 completes normally → 12.
- i_rst_n dropped mid-CALC, asynchronously between edges → o_stall/o_done/o_result immediately 0. After release, back-to-back divu 9/3 then mul 2×5 → results 3 then 10, with no lost or duplicated o_done.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the RV32M iterative multiply/divide unit.
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_FIX,
        ST_DONE
    } md_state_e;

    localparam logic [6:0] OP_MULDIV = 7'b0110011;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    function automatic logic is_muldiv(input logic [6:0] opcode, input logic [6:0] funct7);
        return (opcode == OP_MULDIV) && (funct7 == F7_MULDIV);
    endfunction

    function automatic logic op_is_div(input md_op_e op);
        return op[2];
    endfunction

    // mul is handled as signed x signed; its low word does not depend on it.
    function automatic logic op_a_signed(input md_op_e op);
        return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
               (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic op_b_signed(input md_op_e op);
        return (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Datapath: shared 2*XLEN accumulator doing one shift-add (mul) or one
// restoring trial-subtract (div) step per cycle, plus sign fix-up outputs.
module muldiv_iter
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_load,
    input  logic              i_step,
    input  logic              i_is_div,
    input  logic [XLEN-1:0]   i_mag_a,
    input  logic [XLEN-1:0]   i_mag_b,
    input  logic              i_neg_prod,
    input  logic              i_neg_quot,
    input  logic              i_neg_rem,
    output logic [2*XLEN-1:0] o_prod,
    output logic [XLEN-1:0]   o_quot,
    output logic [XLEN-1:0]   o_rem
);

    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   opnd_q, opnd_d;
    logic              is_div_q, is_div_d;

    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     rem_sh;
    logic [XLEN-1:0]   rem_diff;
    logic              no_borrow;

    always_comb begin
        // Multiply: acc = {partial product, remaining multiplier bits}
        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        // Divide: acc = {partial remainder, dividend/quotient bits}
        rem_sh    = acc_q[2*XLEN-1:XLEN-1];
        no_borrow = (rem_sh >= {1'b0, opnd_q});
        rem_diff  = rem_sh[XLEN-1:0] - opnd_q;

        acc_d    = acc_q;
        opnd_d   = opnd_q;
        is_div_d = is_div_q;
        if (i_load) begin
            is_div_d = i_is_div;
            acc_d    = {{XLEN{1'b0}}, (i_is_div ? i_mag_a : i_mag_b)};
            opnd_d   = i_is_div ? i_mag_b : i_mag_a;
        end else if (i_step) begin
            if (is_div_q)
                acc_d = {(no_borrow ? rem_diff : rem_sh[XLEN-1:0]), acc_q[XLEN-2:0], no_borrow};
            else
                acc_d = {mul_sum, acc_q[XLEN-1:1]};
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            acc_q    <= '0;
            opnd_q   <= '0;
            is_div_q <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            is_div_q <= is_div_d;
        end
    end

    assign o_prod = i_neg_prod ? (~acc_q + 1'b1) : acc_q;
    assign o_quot = i_neg_quot ? (~acc_q[XLEN-1:0] + 1'b1) : acc_q[XLEN-1:0];
    assign o_rem  = i_neg_rem  ? (~acc_q[2*XLEN-1:XLEN] + 1'b1) : acc_q[2*XLEN-1:XLEN];

endmodule

// File: rtl/muldiv_seq.sv
// RV32M multiply/divide sequencer: FSM, iteration counter, special-case
// short-cuts, pipeline stall and registered result with a one-cycle done pulse.
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN)
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_start,
    input  logic [2:0]      i_funct3,
    input  logic [XLEN-1:0] i_operand_a,
    input  logic [XLEN-1:0] i_operand_b,
    input  logic            i_flush,
    output logic            o_stall,
    output logic            o_done,
    output logic [XLEN-1:0] o_result
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0]  INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

    md_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    md_op_e          op_q;
    logic            sa_q, sb_q;
    logic [XLEN-1:0] result_q;
    logic            done_q;

    md_op_e          op_in;
    logic            sa_in, sb_in;
    logic [XLEN-1:0] mag_a, mag_b;
    logic            b_zero, div_ovf, special, accept;
    logic [XLEN-1:0] special_res, fix_res;

    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quot, rem;

    always_comb begin
        op_in   = md_op_e'(i_funct3);
        sa_in   = op_a_signed(op_in) & i_operand_a[XLEN-1];
        sb_in   = op_b_signed(op_in) & i_operand_b[XLEN-1];
        mag_a   = sa_in ? (~i_operand_a + 1'b1) : i_operand_a;
        mag_b   = sb_in ? (~i_operand_b + 1'b1) : i_operand_b;
        b_zero  = (i_operand_b == '0);
        div_ovf = ((op_in == OP_DIV) || (op_in == OP_REM)) &&
                  (i_operand_a == INT_MIN) && (i_operand_b == '1);
        special = op_is_div(op_in) && (b_zero || div_ovf);
        // funct3[1] separates the remainder ops from the quotient ops
        if (b_zero)
            special_res = op_in[1] ? i_operand_a : '1;
        else
            special_res = op_in[1] ? '0 : INT_MIN;
        accept  = (state_q == ST_IDLE) && i_start && !i_flush;
    end

    always_comb begin
        unique case (op_q)
            OP_MUL:                       fix_res = prod[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fix_res = prod[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              fix_res = quot;
            default:                      fix_res = rem;
        endcase
    end

    muldiv_iter #(.XLEN(XLEN)) u_iter (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_load     (accept && !special),
        .i_step     ((state_q == ST_CALC) && !i_flush),
        .i_is_div   (op_is_div(op_in)),
        .i_mag_a    (mag_a),
        .i_mag_b    (mag_b),
        .i_neg_prod (sa_q ^ sb_q),
        .i_neg_quot (sa_q ^ sb_q),
        .i_neg_rem  (sa_q),
        .o_prod     (prod),
        .o_quot     (quot),
        .o_rem      (rem)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            op_q     <= OP_MUL;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (i_flush) begin
                state_q <= ST_IDLE;
            end else begin
                unique case (state_q)
                    ST_IDLE: if (i_start) begin
                        op_q  <= op_in;
                        sa_q  <= sa_in;
                        sb_q  <= sb_in;
                        cnt_q <= '0;
                        if (special) begin
                            result_q <= special_res;
                            done_q   <= 1'b1;
                            state_q  <= ST_DONE;
                        end else begin
                            state_q  <= ST_CALC;
                        end
                    end
                    ST_CALC: begin
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == CNT_LAST)
                            state_q <= ST_FIX;
                    end
                    ST_FIX: begin
                        result_q <= fix_res;
                        done_q   <= 1'b1;
                        state_q  <= ST_DONE;
                    end
                    // start is still the retiring instruction here; ignore it
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign o_stall  = i_rst_n && ((accept) || (state_q == ST_CALC) || (state_q == ST_FIX));
    assign o_done   = done_q;
    assign o_result = result_q;

endmodule
